// File: rtl/i2s_stream_ctrl.sv
// I2S stream engine: Tx FIFO prefetch into a holding word, MSB-first serializer,
// Rx deserializer with a one-word holding register, WS/bit timing from sck_tick.
module i2s_stream_ctrl #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  enable,
  input  logic                  sck_tick,
  input  logic                  Tx_empty,
  input  logic [WORD_WIDTH-1:0] Tx_rdata,
  input  logic                  Rx_full,
  input  logic                  sd_in,
  output logic                  Tx_ren,
  output logic                  Rx_wen,
  output logic [WORD_WIDTH-1:0] Rx_wdata,
  output logic                  sd_out,
  output logic                  ws,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0] WS_BIT   = CW'(WORD_WIDTH - 2);

  logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic                  ws_reg, ws_next;
  logic [WORD_WIDTH-1:0] tx_hold_reg, tx_hold_next;
  logic                  tx_occ_reg, tx_occ_next;
  logic                  tx_pend_reg, tx_pend_next;
  logic                  tx_ren_reg, tx_ren_next;
  logic [WORD_WIDTH-1:0] tx_shift_reg, tx_shift_next;
  logic [WORD_WIDTH-1:0] rx_shift_reg, rx_shift_next;
  logic [WORD_WIDTH-1:0] rx_hold_reg, rx_hold_next;
  logic                  rx_occ_reg, rx_occ_next;
  logic                  rx_armed_reg, rx_armed_next;
  logic                  rx_wen_reg, rx_wen_next;
  logic [WORD_WIDTH-1:0] rx_wdata_reg, rx_wdata_next;
  logic                  underrun_reg, underrun_next;
  logic                  overrun_reg, overrun_next;

  logic                  tick;
  logic                  boundary;
  logic                  push;
  logic                  capture;
  logic                  drop;
  logic [WORD_WIDTH-1:0] rx_word;
  logic [WORD_WIDTH-1:0] tx_shl;

  assign tick     = enable & sck_tick;
  assign boundary = tick & (bit_cnt_reg == LAST_BIT);
  assign rx_word  = {rx_shift_reg[WORD_WIDTH-2:0], sd_in};
  assign push     = enable & rx_occ_reg & ~Rx_full;
  // rx_armed is clear until the first (partial) word after enable has passed.
  assign capture  = boundary & rx_armed_reg & (~rx_occ_reg | push);
  assign drop     = boundary & rx_armed_reg & rx_occ_reg & ~push;

  assign tx_shl[0] = 1'b0;
  for (genvar gi = 1; gi < WORD_WIDTH; gi++) begin : g_shl
    assign tx_shl[gi] = tx_shift_reg[gi-1];
  end

  always_comb begin
    bit_cnt_next  = bit_cnt_reg;
    ws_next       = ws_reg;
    tx_hold_next  = tx_hold_reg;
    tx_occ_next   = tx_occ_reg;
    tx_pend_next  = tx_pend_reg;
    tx_ren_next   = 1'b0;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_hold_next  = rx_hold_reg;
    rx_occ_next   = rx_occ_reg;
    rx_armed_next = rx_armed_reg;
    rx_wen_next   = 1'b0;
    rx_wdata_next = rx_wdata_reg;
    underrun_next = underrun_reg;
    overrun_next  = overrun_reg;

    // A pop already issued always completes so the FIFO word is never lost.
    if (tx_pend_reg && !tx_ren_reg) begin
      tx_hold_next = Tx_rdata;
      tx_occ_next  = 1'b1;
      tx_pend_next = 1'b0;
    end

    if (!enable) begin
      bit_cnt_next  = '0;
      ws_next       = 1'b0;
      tx_shift_next = '0;
      rx_shift_next = '0;
      rx_armed_next = 1'b0;
      underrun_next = 1'b0;
      overrun_next  = 1'b0;
    end else begin
      if (!tx_occ_reg && !tx_pend_reg && !Tx_empty) begin
        tx_ren_next  = 1'b1;
        tx_pend_next = 1'b1;
      end
      if (tick) begin
        bit_cnt_next  = boundary ? '0 : bit_cnt_reg + CW'(1);
        rx_shift_next = rx_word;
        if (bit_cnt_reg == WS_BIT) begin
          ws_next = ~ws_reg;
        end
        if (boundary) begin
          rx_armed_next = 1'b1;
          if (tx_occ_reg) begin
            tx_shift_next = tx_hold_reg;
            tx_occ_next   = 1'b0;
          end else begin
            tx_shift_next = '0;
            underrun_next = 1'b1;
          end
        end else begin
          tx_shift_next = tx_shl;
        end
      end
      if (push) begin
        rx_wen_next   = 1'b1;
        rx_wdata_next = rx_hold_reg;
        rx_occ_next   = 1'b0;
      end
      if (capture) begin
        rx_hold_next = rx_word;
        rx_occ_next  = 1'b1;
      end
      if (drop) begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      bit_cnt_reg  <= '0;
      ws_reg       <= 1'b0;
      tx_hold_reg  <= '0;
      tx_occ_reg   <= 1'b0;
      tx_pend_reg  <= 1'b0;
      tx_ren_reg   <= 1'b0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_hold_reg  <= '0;
      rx_occ_reg   <= 1'b0;
      rx_armed_reg <= 1'b0;
      rx_wen_reg   <= 1'b0;
      rx_wdata_reg <= '0;
      underrun_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      bit_cnt_reg  <= bit_cnt_next;
      ws_reg       <= ws_next;
      tx_hold_reg  <= tx_hold_next;
      tx_occ_reg   <= tx_occ_next;
      tx_pend_reg  <= tx_pend_next;
      tx_ren_reg   <= tx_ren_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_hold_reg  <= rx_hold_next;
      rx_occ_reg   <= rx_occ_next;
      rx_armed_reg <= rx_armed_next;
      rx_wen_reg   <= rx_wen_next;
      rx_wdata_reg <= rx_wdata_next;
      underrun_reg <= underrun_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign Tx_ren   = tx_ren_reg;
  assign Rx_wen   = rx_wen_reg;
  assign Rx_wdata = rx_wdata_reg;
  assign sd_out   = tx_shift_reg[WORD_WIDTH-1];
  assign ws       = ws_reg;
  assign underrun = underrun_reg;
  assign overrun  = overrun_reg;

endmodule
